// File: rtl/bp_table_ctrl_pkg.sv
// Shared types for the branch predictor table controller: entry layout, FSM states,
// queued update record and 2-bit counter helpers.
package bp_table_ctrl_pkg;

  localparam int ADDR_W   = 64;
  localparam int BP_TAG_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    addr_t               target;
    logic [1:0]          ctr;
  } bp_entry_t;

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} bp_state_t;

  typedef struct packed {
    addr_t pc;
    logic  taken;
    addr_t target;
  } bp_upd_t;

  // Saturating step toward the resolved outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table_ctrl_upd_fifo.sv
// Resolved-branch update queue; wrap-bit pointers distinguish full from empty.
// Head entry is read combinationally; push while full is prevented by the caller.
module bp_table_ctrl_upd_fifo
  import bp_table_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  bp_upd_t wdata_i,
  output bp_upd_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(QDEPTH);

  bp_upd_t     mem_q [QDEPTH];
  logic [PW:0] wptr_q;
  logic [PW:0] rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign rdata_o = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q[PW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + (PW+1)'(1);
      end
      if (pop_i) rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Sequences the single-ported predictor SRAM: clear after reset, fetch lookups, queued RMW updates.
// Optional BP_FLUSH_EN adds a flush input that behaves like reset.
module bp_table_ctrl
  import bp_table_ctrl_pkg::*;
#(
  parameter int ENTRIES    = 64,
  parameter int TAG_W      = BP_TAG_W,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       CLK,
  input  logic                       reset,
`ifdef BP_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       lk_valid,
  input  addr_t                      lk_pc,
  output logic                       lk_stall,
  output logic                       pred_valid,
  output logic                       pred_taken,
  output addr_t                      target,
  input  logic                       upd_valid,
  input  addr_t                      upd_pc,
  input  logic                       upd_taken,
  input  addr_t                      upd_target,
  output logic                       upd_ready,
  output logic                       tbl_en,
  output logic                       tbl_we,
  output logic [$clog2(ENTRIES)-1:0] tbl_idx,
  output bp_entry_t                  tbl_wdata,
  input  bp_entry_t                  tbl_rdata
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam int LO    = IDX_W + 2;

  logic clr;
`ifdef BP_FLUSH_EN
  assign clr = reset | flush;
`else
  assign clr = reset;
`endif

  bp_state_t        state_q;
  logic [IDX_W-1:0] init_q;
  logic [SW-1:0]    starve_q;
  bp_entry_t        rd_ent_q;
  logic             lk_pend_q;
  logic [TAG_W-1:0] lk_tag_q;

  bp_upd_t          head;
  bp_upd_t          upd_in;
  logic             q_full, q_empty, q_push, q_pop;
  logic [IDX_W-1:0] lk_idx, head_idx;
  logic [TAG_W-1:0] lk_tag, head_tag;
  logic             starved, lk_acc, denied, lk_hit, upd_hit, need_wr;
  bp_entry_t        wr_ent;
  logic             unused_pc;

  assign lk_idx    = lk_pc[LO-1:2];
  assign lk_tag    = lk_pc[LO +: TAG_W];
  assign head_idx  = head.pc[LO-1:2];
  assign head_tag  = head.pc[LO +: TAG_W];
  assign unused_pc = ^{lk_pc[ADDR_W-1:LO+TAG_W], lk_pc[1:0],
                       head.pc[ADDR_W-1:LO+TAG_W], head.pc[1:0]};

  // Once an update has been deferred STARVE_MAX times, fetch is held off until its RMW pops.
  assign starved   = (starve_q >= SW'(STARVE_MAX));
  assign lk_stall  = clr | (state_q == INIT) | starved;
  assign lk_acc    = lk_valid & ~lk_stall;
  assign q_pop     = ~clr & (state_q == UPD_WR) & ~lk_acc;
  assign upd_ready = ~clr & (~q_full | q_pop);
  assign q_push    = upd_valid & upd_ready;
  assign denied    = lk_acc & (((state_q == IDLE) & ~q_empty) | (state_q == UPD_WR));
  assign upd_in    = '{pc: upd_pc, taken: upd_taken, target: upd_target};

  bp_table_ctrl_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk_i   (CLK),
    .clr_i   (clr),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i (upd_in),
    .rdata_o (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign lk_hit     = tbl_rdata.valid & (tbl_rdata.tag == lk_tag_q);
  assign pred_valid = lk_pend_q;
  assign pred_taken = lk_pend_q & lk_hit & tbl_rdata.ctr[1];
  assign target     = (lk_pend_q & lk_hit) ? tbl_rdata.target : '0;

  always_comb begin
    wr_ent  = rd_ent_q;
    upd_hit = rd_ent_q.valid & (rd_ent_q.tag == head_tag);
    if (upd_hit) begin
      wr_ent.ctr = ctr_step(rd_ent_q.ctr, head.taken);
      if (head.taken) wr_ent.target = head.target;
    end else begin
      wr_ent.valid  = 1'b1;
      wr_ent.tag    = head_tag;
      wr_ent.target = head.target;
      wr_ent.ctr    = CTR_WEAK_T;
    end
    // A not-taken miss leaves the entry alone.
    need_wr = upd_hit | head.taken;
  end

  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_idx   = '0;
    tbl_wdata = '0;
    if (!clr) begin
      case (state_q)
        INIT: begin
          tbl_en  = 1'b1;
          tbl_we  = 1'b1;
          tbl_idx = init_q;
        end
        IDLE: begin
          if (lk_acc) begin
            tbl_en  = 1'b1;
            tbl_idx = lk_idx;
          end else if (!q_empty) begin
            tbl_en  = 1'b1;
            tbl_idx = head_idx;
          end
        end
        UPD_RD: begin
          if (lk_acc) begin
            tbl_en  = 1'b1;
            tbl_idx = lk_idx;
          end
        end
        UPD_WR: begin
          if (lk_acc) begin
            tbl_en  = 1'b1;
            tbl_idx = lk_idx;
          end else if (need_wr) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_idx   = head_idx;
            tbl_wdata = wr_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      state_q   <= INIT;
      init_q    <= '0;
      starve_q  <= '0;
      rd_ent_q  <= '0;
      lk_pend_q <= 1'b0;
      lk_tag_q  <= '0;
    end else begin
      lk_pend_q <= lk_acc;
      lk_tag_q  <= lk_tag;
      if (q_pop) starve_q <= '0;
      else if (denied) starve_q <= starve_q + SW'(1);
      case (state_q)
        INIT: begin
          init_q <= init_q + IDX_W'(1);
          if (init_q == IDX_W'(ENTRIES - 1)) state_q <= IDLE;
        end
        IDLE:    if (!lk_acc && !q_empty) state_q <= UPD_RD;
        UPD_RD: begin
          rd_ent_q <= tbl_rdata;
          state_q  <= UPD_WR;
        end
        UPD_WR:  if (q_pop) state_q <= IDLE;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: SRAM model, vector table, corner sequences and
// randomized updates/lookups against a table-level predictor model.
module tb_bp_table_ctrl;
  import bp_table_ctrl_pkg::*;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic      CLK = 1'b0;
  logic      reset = 1'b1;
`ifdef BP_FLUSH_EN
  logic      flush = 1'b0;
`endif
  logic      lk_valid = 1'b0;
  addr_t     lk_pc = '0;
  logic      lk_stall, pred_valid, pred_taken, upd_ready;
  addr_t     target;
  logic      upd_valid = 1'b0;
  addr_t     upd_pc = '0;
  logic      upd_taken = 1'b0;
  addr_t     upd_target = '0;
  logic      tbl_en, tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  bp_entry_t tbl_wdata;
  bp_entry_t tbl_rdata = '0;

  always #5 CLK = ~CLK;

  bp_table_ctrl dut (
    .CLK        (CLK),
    .reset      (reset),
`ifdef BP_FLUSH_EN
    .flush      (flush),
`endif
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .lk_stall   (lk_stall),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .target     (target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_ready  (upd_ready),
    .tbl_en     (tbl_en),
    .tbl_we     (tbl_we),
    .tbl_idx    (tbl_idx),
    .tbl_wdata  (tbl_wdata),
    .tbl_rdata  (tbl_rdata)
  );

  // Single-port SRAM with one-cycle read latency.
  bp_entry_t sram [ENTRIES];
  always @(posedge CLK) begin
    if (tbl_en) begin
      if (tbl_we) sram[tbl_idx] <= tbl_wdata;
      else        tbl_rdata     <= sram[tbl_idx];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Table-level predictor model.
  int    m_v   [ENTRIES];
  int    m_tag [ENTRIES];
  int    m_ctr [ENTRIES];
  addr_t m_tgt [ENTRIES];

  function automatic void m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_ctr[i] = 0; m_tgt[i] = '0;
    end
  endfunction

  function automatic void m_upd(input addr_t pc, input bit tk, input addr_t tg);
    int i = int'((pc >> 2) % ENTRIES);
    int t = int'((pc >> (IDX_W + 2)) % 256);
    if (m_v[i] == 1 && m_tag[i] == t) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tg;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_v[i] = 1; m_tag[i] = t; m_tgt[i] = tg; m_ctr[i] = 2;
    end
  endfunction

  function automatic void m_look(input addr_t pc, output bit tk, output addr_t tg);
    int i = int'((pc >> 2) % ENTRIES);
    int t = int'((pc >> (IDX_W + 2)) % 256);
    tk = 1'b0;
    tg = '0;
    if (m_v[i] == 1 && m_tag[i] == t) begin
      tk = (m_ctr[i] >= 2);
      tg = m_tgt[i];
    end
  endfunction

  task automatic do_upd(input addr_t pc, input bit tk, input addr_t tg);
    int n = 0;
    @(negedge CLK);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    #1;
    while (!upd_ready && n < 300) begin
      @(negedge CLK); #1; n++;
    end
    chk("upd_accept", upd_ready, 1);
    if (upd_ready) m_upd(pc, tk, tg);
    @(negedge CLK);
    upd_valid = 1'b0;
  endtask

  task automatic lookup_chk(input string nm, input addr_t pc, input bit etk, input addr_t etg);
    int n = 0;
    @(negedge CLK);
    lk_valid = 1'b1; lk_pc = pc;
    #1;
    while (lk_stall && n < 300) begin
      @(negedge CLK); #1; n++;
    end
    chk({nm, "_accept"}, lk_stall, 0);
    @(negedge CLK);
    lk_valid = 1'b0;
    #1;
    chk({nm, "_pred_valid"}, pred_valid, 1);
    chk({nm, "_pred_taken"}, pred_taken, etk);
    chk({nm, "_target"}, target, etg);
  endtask

  task automatic pulse_clear();
`ifdef BP_FLUSH_EN
    flush = 1'b1;
`else
    reset = 1'b1;
`endif
  endtask

  task automatic release_clear();
`ifdef BP_FLUSH_EN
    flush = 1'b0;
`else
    reset = 1'b0;
`endif
  endtask

  typedef struct {
    bit    is_upd;
    addr_t pc;
    bit    tk;
    addr_t tg;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_u(input addr_t pc, input bit tk, input addr_t tg);
    vec_t v;
    v.is_upd = 1'b1; v.pc = pc; v.tk = tk; v.tg = tg;
    vecs.push_back(v);
  endfunction

  // For a lookup record, tk/tg hold the expected prediction.
  function automatic void add_l(input addr_t pc, input bit etk, input addr_t etg);
    vec_t v;
    v.is_upd = 1'b0; v.pc = pc; v.tk = etk; v.tg = etg;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int    we_cnt, bad, stall_bad, n0, n1, phase, k, early, rdy0;
    logic  last_we, fifth_we, fifth_stall;
    logic [IDX_W-1:0] last_idx, fifth_idx;
    bit    etk;
    addr_t etg, pc;

    for (int i = 0; i < ENTRIES; i++) sram[i] = '{valid: 1'b1, tag: 8'h10, target: 64'hdead, ctr: 2'b11};
    m_clear();

    // Reset values
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_lk_stall", lk_stall, 1);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_target", target, 0);

    // Table clear sweep
    reset = 1'b0;
    we_cnt = 0; bad = 0; stall_bad = 0;
    for (int c = 0; c < 70; c++) begin
      #1;
      if (tbl_we) begin
        if (int'(tbl_idx) != we_cnt || tbl_wdata != '0) bad++;
        if (!lk_stall) stall_bad++;
        we_cnt++;
      end
      @(negedge CLK);
    end
    #1;
    chk("init_write_count", we_cnt, 64);
    chk("init_idx_order", bad, 0);
    chk("init_stall_held", stall_bad, 0);
    chk("init_done_stall", lk_stall, 0);

    // Directed vectors
    add_l(64'h1000, 0, 64'h0);
    add_u(64'h1000, 1, 64'h2000);  add_l(64'h1000, 1, 64'h2000);
    add_u(64'h1000, 0, 64'h0);     add_l(64'h1000, 0, 64'h2000);
    add_u(64'h1000, 0, 64'h0);     add_u(64'h1000, 0, 64'h0);
    add_l(64'h1000, 0, 64'h2000);
    add_u(64'h1000, 1, 64'h3000);  add_l(64'h1000, 0, 64'h3000);
    add_u(64'h1000, 1, 64'h3000);  add_l(64'h1000, 1, 64'h3000);
    add_u(64'h5000, 0, 64'h0);     add_l(64'h1000, 1, 64'h3000);
    add_l(64'h5000, 0, 64'h0);
    add_u(64'h5000, 1, 64'h6000);  add_l(64'h5000, 1, 64'h6000);
    add_l(64'h1000, 0, 64'h0);
    add_u(64'h5000, 1, 64'h7000);  add_u(64'h5000, 1, 64'h7000);
    add_u(64'h5000, 0, 64'h0);     add_l(64'h15000, 1, 64'h7000);
    add_l(64'h1004, 0, 64'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_upd) begin
        do_upd(vecs[i].pc, vecs[i].tk, vecs[i].tg);
        repeat (12) @(negedge CLK);
      end else begin
        lookup_chk($sformatf("vec%0d", i), vecs[i].pc, vecs[i].tk, vecs[i].tg);
      end
    end

    // Starvation: one queued update against continuous lookups
    @(negedge CLK);
    upd_valid = 1'b1; upd_pc = 64'h2008; upd_taken = 1'b1; upd_target = 64'habc0;
    lk_valid = 1'b1; lk_pc = 64'h40;
    #1;
    chk("starve_enq_ready", upd_ready, 1);
    m_upd(64'h2008, 1, 64'habc0);
    @(negedge CLK);
    upd_valid = 1'b0;
    n0 = 0; n1 = 0; phase = 0; last_we = 1'b0; last_idx = '0;
    for (int c = 0; c < 40 && phase != 2; c++) begin
      #1;
      if (phase == 0) begin
        if (!lk_stall) n0++;
        else phase = 1;
      end
      if (phase == 1) begin
        if (lk_stall) begin
          n1++; last_we = tbl_we; last_idx = tbl_idx;
        end else phase = 2;
      end
      if (phase != 2) @(negedge CLK);
    end
    lk_valid = 1'b0;
    chk("starve_finished", phase, 2);
    chk("starve_free_cycles", n0, 8);
    chk("starve_stall_cycles", n1, 3);
    chk("starve_last_we", last_we, 1);
    chk("starve_write_idx", last_idx, 2);
    repeat (8) @(negedge CLK);
    m_look(64'h2008, etk, etg);
    lookup_chk("starve_result", 64'h2008, etk, etg);

    // Full queue: five updates while fetch keeps the port busy
    @(negedge CLK);
    lk_valid = 1'b1; lk_pc = 64'h80;
    k = 0; early = 0; rdy0 = 0; fifth_we = 1'b0; fifth_stall = 1'b0; fifth_idx = '1;
    upd_valid = 1'b1; upd_pc = 64'h3000; upd_taken = 1'b1; upd_target = 64'h7100;
    for (int c = 0; c < 60 && k < 5; c++) begin
      #1;
      if (upd_ready) begin
        m_upd(upd_pc, upd_taken, upd_target);
        if (k == 4) begin
          fifth_we = tbl_we; fifth_stall = lk_stall; fifth_idx = tbl_idx;
        end
        k++;
      end else if (k == 4) rdy0++;
      else early++;
      @(negedge CLK);
      if (k < 5) begin
        upd_pc = 64'h3000 + addr_t'(k * 4); upd_target = 64'h7100 + addr_t'(k);
      end else upd_valid = 1'b0;
    end
    upd_valid = 1'b0; lk_valid = 1'b0;
    chk("full_pushed", k, 5);
    chk("full_no_early_block", early, 0);
    chk("full_ready_low_cycles", rdy0, 7);
    chk("full_pop_same_cycle_we", fifth_we, 1);
    chk("full_pop_stalled", fifth_stall, 1);
    chk("full_pop_idx", fifth_idx, 0);
    repeat (30) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      pc = 64'h3000 + addr_t'(i * 4);
      m_look(pc, etk, etg);
      lookup_chk($sformatf("full_res%0d", i), pc, etk, etg);
    end

    // Clear during UPD_WR abandons the write and restarts the sweep
    do_upd(64'h4014, 1, 64'h9990);
    n0 = 0;
    #1;
    while (!(tbl_en && !tbl_we) && n0 < 20) begin
      @(negedge CLK); #1; n0++;
    end
    chk("rmw_read_seen", tbl_en && !tbl_we, 1);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rmw_write_pending", tbl_we, 1);
    pulse_clear();
    #1;
    chk("clear_blocks_write", tbl_we, 0);
    @(negedge CLK);
    release_clear();
    #1;
    chk("init_restart_we", tbl_we, 1);
    chk("init_restart_idx", tbl_idx, 0);
    chk("init_restart_stall", lk_stall, 1);
    m_clear();
    repeat (70) @(negedge CLK);
    lookup_chk("after_clear", 64'h4014, 0, 64'h0);
    lookup_chk("after_clear_old", 64'h5000, 0, 64'h0);

    // Randomized update batches followed by lookups against the model
    for (int it = 0; it < 40; it++) begin
      int nu = $urandom_range(1, 4);
      for (int u = 0; u < nu; u++) begin
        pc = (addr_t'($urandom_range(0, 3)) << 8) | (addr_t'($urandom_range(0, 7)) << 2)
           | (addr_t'($urandom_range(0, 3)) << 16);
        do_upd(pc, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      end
      repeat (4 * 4 + 6) @(negedge CLK);
      for (int l = 0; l < 3; l++) begin
        pc = (addr_t'($urandom_range(0, 3)) << 8) | (addr_t'($urandom_range(0, 7)) << 2)
           | (addr_t'($urandom_range(0, 3)) << 16);
        m_look(pc, etk, etg);
        lookup_chk($sformatf("rnd%0d_%0d", it, l), pc, etk, etg);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
- Sequences the single-ported branch predictor table SRAM (tag, target, 2-bit counter per entry).
- Serves fetch lookups and buffers resolved-branch updates from execute in a small queue.
- Drains updates as read-modify-write in cycles where fetch does not use the port; clears the table after reset.
- Sits between fetch/execute and the predictor table; provides pred_taken/target to fetch.

Parameters:
ENTRIES, 64, number of table entries (power of 2)
TAG_W, 8, tag bits stored per entry
QDEPTH, 4, update queue depth (power of 2)
STARVE_MAX, 8, consecutive deferred update cycles before fetch is stalled

Ports:
CLK  in  1  clock
reset  in  1  synchronous active-high reset
lk_valid  in  1  fetch lookup request this cycle
lk_pc  in  64  fetch PC (addr_t)
lk_stall  out  1  lookup not accepted this cycle
pred_valid  out  1  lookup result valid (cycle after accepted lookup)
pred_taken  out  1  predicted taken
target  out  64  predicted target (addr_t)
upd_valid  in  1  resolved branch update
upd_pc  in  64  branch PC
upd_taken  in  1  actual outcome
upd_target  in  64  resolved target
upd_ready  out  1  queue not full
tbl_en  out  1  SRAM access
tbl_we  out  1  SRAM write
tbl_idx  out  log2(ENTRIES)  SRAM index
tbl_wdata  out  bp_entry_t  write data
tbl_rdata  in  bp_entry_t  read data (1-cycle latency)

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+2 +: TAG_W].
- Reset: all outputs 0 except lk_stall=1; queue emptied; FSM -> INIT, init counter 0.
- INIT: writes zero entry to idx 0..ENTRIES-1, one per cycle (ENTRIES cycles); lk_stall=1; updates are enqueued but not drained; -> IDLE after last index.
- IDLE: lookup has port priority. An accepted lookup (lk_valid & !lk_stall) reads the table. Next cycle: pred_valid=1; pred_taken = valid & tag match & ctr[1]; target = entry target on a hit, else 0.
- Free port cycle and queue non-empty: read head index -> UPD_RD.
- UPD_RD: latch tbl_rdata -> UPD_WR.
- UPD_WR, hit (valid & tag match): counter +1 on taken (saturate 3), -1 on not-taken (saturate 0); target overwritten on taken.
- UPD_WR, miss: allocate only if taken (valid=1, tag, target, ctr=2); otherwise no write.
- UPD_WR completes: the write is issued in the first free port cycle; pop queue; -> IDLE.
- Starvation: a starve counter increments each cycle the port is denied to a pending update (UPD_WR waiting, or IDLE with a non-empty queue); it resets on a pop.
  - At STARVE_MAX: lk_stall=1 until the pending RMW completes.
- Lookup of an index between its update read and write returns pre-update data; this is accepted.
- Queue: enqueue on upd_valid & upd_ready. Full -> upd_ready=0 and the update is dropped by the producer's choice (execute must hold).
  - Simultaneous enqueue and pop when full: the pop frees the slot in the same cycle, so upd_ready follows !full-after-pop.
- Pointers wrap modulo QDEPTH with an extra wrap bit for the full/empty distinction.
- reset mid-RMW: the RMW is abandoned with no write; INIT restarts.

Optional Feature:
BP_FLUSH_EN: adds input flush (1 bit).
- flush=1 in any state aborts an in-flight RMW, empties the queue and re-enters INIT next cycle (same as reset, but the queue clear is explicit).
- Without the macro: no flush port; the table is cleared only by reset.

Decomposition:
- types_pkg gains:
  - bp_entry_t (valid, tag[TAG_W], target addr_t, ctr[2]).
  - bp_state_t enum {INIT, IDLE, UPD_RD, UPD_WR}.
  - bp_upd_t (pc, taken, target).
  - Counter constants CTR_WEAK_T=2'b10, CTR_MAX=2'b11.
- Sub-module bp_upd_fifo (parameterised QDEPTH, bp_upd_t payload, full/empty/count) is natural.

Test Plan:
- Reset, hold 70 cycles -> tbl_we=1 on idx 0..63 for 64 cycles, lk_stall=1 throughout, then lk_stall=0.
- Update pc=0x1000 taken target=0x2000, then lookup 0x1000 -> pred_valid=1, pred_taken=1, target=0x2000 (ctr=2).
- Three not-taken updates on 0x1000 -> ctr 2->1->0->0 (saturates); next lookup pred_taken=0.
- lk_valid held 1 with one update queued -> after 8 deferred cycles lk_stall=1 exactly until the write issues; the queue pops.
- Enqueue 5 updates with no free port -> upd_ready=0 after 4; on the first pop upd_ready=1 in the same cycle as a fifth enqueue.
- Assert reset during UPD_WR -> no tbl_we for that entry; INIT restarts at idx 0; with BP_FLUSH_EN the same behaviour is required via flush.
